// File: rtl/uart_spi_bridge.sv
// rtl/uart_spi_bridge.sv - framed UART byte stream to 24-bit SPI register writes
module uart_spi_bridge #(
    parameter int          CLKS_PER_HALF_SCK = 4,
    parameter logic [7:0]  SYNC_BYTE         = 8'hA5,
    parameter int          TIMEOUT_CLKS      = 1740
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_SEN,
    output logic       o_SCK,
    output logic       o_SDAT,
    output logic       o_Busy,
    output logic       o_Cmd_Done,
    output logic       o_Err_Timeout,
    output logic       o_Err_Overflow
);
    localparam int CW = $clog2(CLKS_PER_HALF_SCK);
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_HALF_SCK - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {P_SYNC, P_ADDR, P_DHI, P_DLO} p_state_t;
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} e_state_t;

    p_state_t        p_state, p_next;
    logic [TW-1:0]   gap_cnt, gap_next;
    logic [7:0]      addr_q, dhi_q;
    logic            frame_done, gap_expired;

    logic            pend_valid;
    logic [23:0]     pend_word;
    logic            eng_load;

    e_state_t        e_state, e_next;
    logic [CW-1:0]   e_cnt, e_cnt_next;
    logic [4:0]      bit_idx, bit_idx_next;
    logic [23:0]     shreg, shreg_next;
    logic            sen_next, sck_next, sdat_next, done_next;

    // Parser: a byte always beats a gap timeout landing in the same cycle.
    always_comb begin
        p_next      = p_state;
        gap_next    = gap_cnt;
        frame_done  = 1'b0;
        gap_expired = 1'b0;
        if (i_Rx_DV) begin
            gap_next = '0;
            case (p_state)
                P_SYNC:  if (i_Rx_Byte == SYNC_BYTE) p_next = P_ADDR;
                P_ADDR:  p_next = P_DHI;
                P_DHI:   p_next = P_DLO;
                default: begin
                    p_next     = P_SYNC;
                    frame_done = 1'b1;
                end
            endcase
        end else if (p_state != P_SYNC) begin
            if (gap_cnt == GAP_LAST) begin
                gap_expired = 1'b1;
                p_next      = P_SYNC;
                gap_next    = '0;
            end else begin
                gap_next = gap_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            p_state <= P_SYNC;
            gap_cnt <= '0;
            addr_q  <= '0;
            dhi_q   <= '0;
        end else begin
            p_state <= p_next;
            gap_cnt <= gap_next;
            if (i_Rx_DV && p_state == P_ADDR) addr_q <= i_Rx_Byte;
            if (i_Rx_DV && p_state == P_DHI)  dhi_q  <= i_Rx_Byte;
        end
    end

    // Engine: every SCK edge and SDAT change falls on a half-period boundary.
    always_comb begin
        e_next       = e_state;
        e_cnt_next   = e_cnt;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        sen_next     = o_SEN;
        sck_next     = o_SCK;
        sdat_next    = o_SDAT;
        done_next    = 1'b0;
        eng_load     = 1'b0;
        case (e_state)
            S_IDLE: begin
                if (pend_valid) begin
                    eng_load   = 1'b1;
                    shreg_next = pend_word;
                    sen_next   = 1'b0;
                    sdat_next  = pend_word[23];
                    e_cnt_next = '0;
                    e_next     = S_SETUP;
                end
            end
            S_SETUP: begin
                if (e_cnt == HALF_LAST) begin
                    e_cnt_next   = '0;
                    sck_next     = 1'b1;
                    bit_idx_next = '0;
                    e_next       = S_SHIFT;
                end else begin
                    e_cnt_next = e_cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                if (e_cnt == HALF_LAST) begin
                    e_cnt_next = '0;
                    if (o_SCK) begin
                        sck_next = 1'b0;
                        if (bit_idx == 5'd23) begin
                            sdat_next = 1'b0;
                            e_next    = S_HOLD;
                        end else begin
                            sdat_next    = shreg[22];
                            shreg_next   = {shreg[22:0], 1'b0};
                            bit_idx_next = bit_idx + 1'b1;
                        end
                    end else begin
                        sck_next = 1'b1;
                    end
                end else begin
                    e_cnt_next = e_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (e_cnt == HALF_LAST) begin
                    e_cnt_next = '0;
                    sen_next   = 1'b1;
                    e_next     = S_GAP;
                end else begin
                    e_cnt_next = e_cnt + 1'b1;
                end
            end
            default: begin
                if (e_cnt == HALF_LAST) begin
                    e_cnt_next = '0;
                    done_next  = 1'b1;
                    e_next     = S_IDLE;
                end else begin
                    e_cnt_next = e_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            e_state        <= S_IDLE;
            e_cnt          <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            o_SEN          <= 1'b1;
            o_SCK          <= 1'b0;
            o_SDAT         <= 1'b0;
            o_Cmd_Done     <= 1'b0;
            pend_valid     <= 1'b0;
            pend_word      <= '0;
            o_Busy         <= 1'b0;
            o_Err_Timeout  <= 1'b0;
            o_Err_Overflow <= 1'b0;
        end else begin
            e_state        <= e_next;
            e_cnt          <= e_cnt_next;
            bit_idx        <= bit_idx_next;
            shreg          <= shreg_next;
            o_SEN          <= sen_next;
            o_SCK          <= sck_next;
            o_SDAT         <= sdat_next;
            o_Cmd_Done     <= done_next;
            o_Err_Timeout  <= gap_expired;
            o_Err_Overflow <= frame_done && pend_valid && !eng_load;
            o_Busy         <= (frame_done && (!pend_valid || eng_load))
                              || (pend_valid && !eng_load) || (e_next != S_IDLE);
            // A slot freed by the engine this cycle can be refilled immediately.
            if (frame_done && (!pend_valid || eng_load)) begin
                pend_valid <= 1'b1;
                pend_word  <= {addr_q, dhi_q, i_Rx_Byte};
            end else if (eng_load) begin
                pend_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_spi_bridge.sv
// tb/tb_uart_spi_bridge.sv - randomized and directed bench for uart_spi_bridge
module tb_uart_spi_bridge;
    logic       i_Clock = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Rx_DV = 1'b0;
    logic [7:0] i_Rx_Byte = 8'h00;
    logic       o_SEN, o_SCK, o_SDAT, o_Busy, o_Cmd_Done, o_Err_Timeout, o_Err_Overflow;

    uart_spi_bridge dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
        .o_SEN(o_SEN), .o_SCK(o_SCK), .o_SDAT(o_SDAT), .o_Busy(o_Busy),
        .o_Cmd_Done(o_Cmd_Done), .o_Err_Timeout(o_Err_Timeout), .o_Err_Overflow(o_Err_Overflow)
    );

    always #5 i_Clock = ~i_Clock;

    int total = 0, passed = 0;
    int cyc = 0, last_dv = 0;

    // SPI slave / pulse monitor, sampling 1 time unit after each rising edge
    logic        sen_q = 1'b1, sck_q = 1'b0;
    logic [23:0] shift_w = '0;
    int          nsck = 0, t0 = 0;
    logic [23:0] words[$];
    int          nscks[$], lows[$];
    int          done_cnt = 0, done_cyc = 0, tmo_cnt = 0, tmo_cyc = 0, ovf_cnt = 0;

    always @(posedge i_Clock) begin
        cyc++;
        #1;
        if (sen_q === 1'b1 && o_SEN === 1'b0) begin
            t0 = cyc; shift_w = '0; nsck = 0;
        end
        if (sck_q === 1'b0 && o_SCK === 1'b1) begin
            shift_w = {shift_w[22:0], o_SDAT}; nsck++;
        end
        if (sen_q === 1'b0 && o_SEN === 1'b1) begin
            words.push_back(shift_w); nscks.push_back(nsck); lows.push_back(cyc - t0);
        end
        if (o_Cmd_Done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (o_Err_Timeout === 1'b1) begin tmo_cnt++; tmo_cyc = cyc; end
        if (o_Err_Overflow === 1'b1) ovf_cnt++;
        sen_q = o_SEN;
        sck_q = o_SCK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d want < 100000", cyc);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_Clock);
            #2;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        i_Rx_DV = 1'b1;
        i_Rx_Byte = b;
        last_dv = cyc;
        tick(1);
        i_Rx_DV = 1'b0;
        tick(gap);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((o_Busy !== 1'b0 || o_SEN !== 1'b1) && k < 3000) begin
            tick(1);
            k++;
        end
        if (k >= 3000) begin
            total++;
            $display("FAIL idle_wait: busy=%b sen=%b still active after %0d cycles", o_Busy, o_SEN, k);
        end
        tick(2);
    endtask

    task automatic clear_mon();
        words.delete(); nscks.delete(); lows.delete();
        done_cnt = 0; tmo_cnt = 0; ovf_cnt = 0;
    endtask

    // Reference: each SYNC byte found while hunting starts a frame whose
    // next three bytes become one word, MSB first.
    function automatic void model(input logic [7:0] bs[$], output logic [23:0] exp_q[$]);
        int i = 0;
        exp_q.delete();
        while (i < bs.size()) begin
            if (bs[i] == 8'hA5 && i + 3 < bs.size()) begin
                exp_q.push_back({bs[i+1], bs[i+2], bs[i+3]});
                i += 4;
            end else begin
                i++;
            end
        end
    endfunction

    task automatic test_reset();
        i_Reset = 1'b1;
        tick(3);
        total++; if (o_SEN !== 1'b1) $display("FAIL reset_sen: got %b want 1", o_SEN); else passed++;
        total++; if (o_SCK !== 1'b0) $display("FAIL reset_sck: got %b want 0", o_SCK); else passed++;
        total++; if (o_SDAT !== 1'b0) $display("FAIL reset_sdat: got %b want 0", o_SDAT); else passed++;
        total++; if (o_Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_Busy); else passed++;
        total++;
        if ({o_Cmd_Done, o_Err_Timeout, o_Err_Overflow} !== 3'b000)
            $display("FAIL reset_pulses: got %b want 000", {o_Cmd_Done, o_Err_Timeout, o_Err_Overflow});
        else passed++;
        i_Reset = 1'b0;
        tick(2);
    endtask

    task automatic test_single();
        logic [23:0] got;
        int dv;
        clear_mon();
        send_byte(8'hA5, 5); send_byte(8'h12, 5); send_byte(8'hBE, 5); send_byte(8'hEF, 0);
        dv = last_dv;
        wait_idle();
        got = (words.size() > 0) ? words[0] : 24'hxxxxxx;
        total++; if (words.size() != 1) $display("FAIL single_count: got %0d words want 1", words.size()); else passed++;
        total++; if (got !== 24'h12BEEF) $display("FAIL single_word: got %h want 12beef", got); else passed++;
        total++; if (nscks.size() < 1 || nscks[0] != 24) $display("FAIL single_sck: got %0d pulses want 24", (nscks.size() > 0) ? nscks[0] : -1); else passed++;
        total++; if (lows.size() < 1 || lows[0] != 196) $display("FAIL single_sen_low: got %0d want 196", (lows.size() > 0) ? lows[0] : -1); else passed++;
        total++; if (t0 - dv != 2) $display("FAIL single_latency: got %0d want 2", t0 - dv); else passed++;
        total++; if (done_cnt != 1) $display("FAIL single_done_cnt: got %0d want 1", done_cnt); else passed++;
        total++; if (done_cyc - t0 != 200) $display("FAIL single_done_time: got %0d want 200", done_cyc - t0); else passed++;
        total++; if (o_Busy !== 1'b0) $display("FAIL single_busy_after: got %b want 0", o_Busy); else passed++;
    endtask

    task automatic test_garbage();
        logic [7:0] bs[$] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h02};
        clear_mon();
        foreach (bs[i]) send_byte(bs[i], 4);
        wait_idle();
        total++; if (words.size() != 1 || words[0] !== 24'h010002) $display("FAIL garbage_word: got %0d words first %h want 1 word 010002", words.size(), (words.size() > 0) ? words[0] : 24'h0); else passed++;
        total++; if (tmo_cnt + ovf_cnt != 0) $display("FAIL garbage_errors: got %0d want 0", tmo_cnt + ovf_cnt); else passed++;
    endtask

    task automatic test_timeout();
        int dv;
        clear_mon();
        send_byte(8'hA5, 3); send_byte(8'h33, 0);
        dv = last_dv;
        tick(1800);
        total++; if (tmo_cnt != 1) $display("FAIL timeout_cnt: got %0d want 1", tmo_cnt); else passed++;
        total++; if (tmo_cyc - dv != 1741) $display("FAIL timeout_time: got %0d want 1741", tmo_cyc - dv); else passed++;
        total++; if (words.size() != 0) $display("FAIL timeout_spi: got %0d words want 0", words.size()); else passed++;
        send_byte(8'hA5, 3); send_byte(8'h44, 3); send_byte(8'h55, 3); send_byte(8'h66, 0);
        wait_idle();
        total++; if (words.size() != 1 || words[0] !== 24'h445566) $display("FAIL timeout_recover: got %0d words first %h want 445566", words.size(), (words.size() > 0) ? words[0] : 24'h0); else passed++;
    endtask

    task automatic test_gap_boundary();
        int dv;
        clear_mon();
        send_byte(8'hA5, 2); send_byte(8'h77, 0);
        dv = last_dv;
        tick(dv + 1740 - cyc);
        send_byte(8'h88, 3); send_byte(8'h99, 0);
        wait_idle();
        total++; if (tmo_cnt != 0) $display("FAIL gap_last_cycle_timeout: got %0d want 0", tmo_cnt); else passed++;
        total++; if (words.size() != 1 || words[0] !== 24'h778899) $display("FAIL gap_last_cycle_word: got %0d words first %h want 778899", words.size(), (words.size() > 0) ? words[0] : 24'h0); else passed++;
        clear_mon();
        send_byte(8'hA5, 2); send_byte(8'h77, 0);
        dv = last_dv;
        tick(dv + 1741 - cyc);
        send_byte(8'h12, 3); send_byte(8'h34, 3); send_byte(8'h56, 0);
        tick(300);
        total++; if (tmo_cnt != 1) $display("FAIL gap_late_timeout: got %0d want 1", tmo_cnt); else passed++;
        total++; if (words.size() != 0) $display("FAIL gap_late_spi: got %0d words want 0", words.size()); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bs[$] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'hA5, 8'h44, 8'h55, 8'h66,
                              8'hA5, 8'h77, 8'h88, 8'h99};
        clear_mon();
        foreach (bs[i]) send_byte(bs[i], 19);
        wait_idle();
        total++; if (words.size() != 2) $display("FAIL b2b_count: got %0d words want 2", words.size()); else passed++;
        total++; if (words.size() < 2 || words[0] !== 24'h112233 || words[1] !== 24'h445566) $display("FAIL b2b_words: got %h %h want 112233 445566", (words.size() > 0) ? words[0] : 24'h0, (words.size() > 1) ? words[1] : 24'h0); else passed++;
        total++; if (ovf_cnt != 1) $display("FAIL b2b_overflow: got %0d want 1", ovf_cnt); else passed++;
        total++; if (done_cnt != 2) $display("FAIL b2b_done: got %0d want 2", done_cnt); else passed++;
    endtask

    task automatic test_sync_data();
        clear_mon();
        repeat (4) send_byte(8'hA5, 3);
        wait_idle();
        total++; if (words.size() != 1 || words[0] !== 24'hA5A5A5) $display("FAIL sync_data: got %0d words first %h want a5a5a5", words.size(), (words.size() > 0) ? words[0] : 24'h0); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] bs[$] = '{8'hA5, 8'hAB, 8'hCD, 8'hEF, 8'hA5, 8'h01, 8'h23, 8'h45};
        clear_mon();
        foreach (bs[i]) send_byte(bs[i], 2);
        tick(t0 + 60 - cyc);
        i_Reset = 1'b1;
        tick(1);
        i_Reset = 1'b0;
        total++; if (o_SEN !== 1'b1) $display("FAIL midreset_sen: got %b want 1", o_SEN); else passed++;
        total++; if (o_SCK !== 1'b0) $display("FAIL midreset_sck: got %b want 0", o_SCK); else passed++;
        tick(400);
        total++; if (done_cnt != 0) $display("FAIL midreset_done: got %0d want 0", done_cnt); else passed++;
        total++; if (words.size() != 1 || nscks[0] >= 24) $display("FAIL midreset_pending_lost: got %0d transfers want 1 partial", words.size()); else passed++;
        clear_mon();
        send_byte(8'hA5, 3); send_byte(8'h5A, 3); send_byte(8'hC3, 3); send_byte(8'h3C, 0);
        wait_idle();
        total++; if (words.size() != 1 || words[0] !== 24'h5AC33C) $display("FAIL midreset_recover: got %0d words first %h want 5ac33c", words.size(), (words.size() > 0) ? words[0] : 24'h0); else passed++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [7:0]  bs[$];
            logic [23:0] exp_q[$];
            int ng = $urandom_range(0, 3);
            for (int g = 0; g < ng; g++) begin
                logic [7:0] b = 8'($urandom_range(0, 255));
                bs.push_back((b == 8'hA5) ? 8'h3C : b);
            end
            bs.push_back(8'hA5);
            for (int d = 0; d < 3; d++) bs.push_back(8'($urandom_range(0, 255)));
            model(bs, exp_q);
            clear_mon();
            foreach (bs[i]) send_byte(bs[i], $urandom_range(1, 30));
            wait_idle();
            total++;
            if (words.size() != exp_q.size() || words.size() != 1 || words[0] !== exp_q[0])
                $display("FAIL random_%0d: got %0d words first %h want %0d words first %h", it,
                         words.size(), (words.size() > 0) ? words[0] : 24'h0,
                         exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : 24'h0);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_garbage();
        test_timeout();
        test_gap_boundary();
        test_back_to_back();
        test_sync_data();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
